instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the RISC-V core: holds the program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It presents instruction/PC pairs to the decode stage with a valid/ready handshake. Taken branches and jumps from execute redirect it via `redirect`/`redirect_pc`, which flushes all in-flight and buffered instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 4: FIFO entries and the maximum number of outstanding requests; a power of two, ≥2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address; bits [1:0] always 0 on a granted request.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; responses return in request order.
- `imem_rdata`  in  32  response instruction word.
- `redirect`  in  1  pipeline redirect strobe.
- `redirect_pc`  in  32  new fetch PC.
- `instr_valid`  out  1  instruction available to decode.
- `instr`  out  32  instruction word to decode.
- `instr_pc`  out  32  PC of `instr`.
- `instr_ready`  in  1  decode accepts the instruction.
- `misalign_exc`  out  1  misaligned redirect trap; present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- States: FETCH, DRAIN, and HALT (only with the macro). Reset enters FETCH.
- FETCH: assert `imem_req` when `outstanding + fifo_count < DEPTH`. A request is granted when `imem_req && imem_gnt`; on grant, pc <= pc + 4 (mod 2^32, wraps silently) and outstanding increments.
- Once asserted, `imem_req`/`imem_addr` hold stable until grant. Redirect is the only exception: it may drop an ungranted request.
- On `imem_rvalid`: if discard_cnt > 0, drop the word and decrement discard_cnt. Otherwise push {`imem_rdata`, pc of that request} into the FIFO. Either way, outstanding decrements.
- The PC of each request is tracked in a DEPTH-entry PC queue alongside the outstanding counter.
- FIFO head drives `instr`/`instr_pc`; `instr_valid` = FIFO non-empty. Pop on `instr_valid && instr_ready`.
- Redirect has priority over all other events in the same cycle:
  - flush the FIFO;
  - pc <= `redirect_pc`;
  - discard_cnt <= outstanding, plus 1 if a grant occurs this cycle, minus 1 if `imem_rvalid` this cycle;
  - go to DRAIN if the result is >0, else FETCH.
- Same-cycle pop and redirect: the pop counts as consumed, then the FIFO is flushed.
- DRAIN: `imem_req` = 0. When discard_cnt reaches 0, go to FETCH; the first request is issued the following cycle.
- A redirect while in DRAIN accumulates: it reloads pc, and the discard count continues.
- Full FIFO: no requests are issued, so a response never overflows the FIFO. A response arriving with outstanding = 0 is a protocol error; the bench asserts on it.

## Timing
- Reset values:
  - `imem_req` 0, `imem_addr` RESET_PC, `instr_valid` 0, `instr` 0, `instr_pc` 0, `misalign_exc` 0;
  - FIFO empty, outstanding 0, discard_cnt 0.
- `rst` mid-operation discards everything, including in-flight responses. Memory must be reset with the core.
- First `imem_req` = 1 in the first cycle after `rst` falls, with `imem_addr` = RESET_PC.
- Response latency: `imem_rvalid` at cycle M gives `instr_valid` at M+1 (registered FIFO, no bypass).
- Throughput: 1 instruction/cycle with 1-cycle memory latency and DEPTH ≥ 3.
- Redirect at cycle R: `instr_valid` = 0 at R+1. The earliest request to `redirect_pc` is at R+1 if nothing is outstanding.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0] != 0` flushes as normal, enters HALT, and sets `misalign_exc` = 1 (sticky until `rst`);
  - HALT issues no requests;
  - outstanding responses are still counted and dropped.
- Undefined: `redirect_pc[1:0]` is forced to 0, there is no HALT state, and the `misalign_exc` port is absent.

## Test plan
- Reset release, 1-cycle memory, `instr_ready` = 1 -> addrs 0x0, 0x4, 0x8… on consecutive cycles; `instr_pc` 0x0 appears 2 cycles after the first grant, then one per cycle.
- `instr_ready` = 0 for 10 cycles -> exactly DEPTH (4) words buffered, `imem_req` = 0 while full, and no words lost when ready returns.
- Redirect to 0x100 with 2 outstanding, memory latency 3 -> both old responses dropped, no request until they return, next `instr_pc` = 0x100.
- Redirect in the same cycle as `imem_rvalid`, a grant, and a pop -> discard_cnt correct, FIFO empty next cycle, no stale instruction delivered.
- PC 0xFFFF_FFFC fetched -> next addr 0x0000_0000.
- With macro: redirect to 0x102 -> `misalign_exc` = 1 next cycle and stays set, `imem_req` stays 0. Without macro: the fetch goes to 0x100.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem request/grant/response, and a small instruction FIFO to decode.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirects into a sticky HALT with misalign_exc.
//
// state | meaning
// FETCH | issue requests while outstanding + buffered < DEPTH
// DRAIN | no requests; discarding responses fetched before a redirect
// HALT  | misaligned redirect trapped; no requests until rst (macro only)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_exc
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, DRAIN} state_t;
`endif

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] discard_nxt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   inflight;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pcq_wr;
  logic [PW-1:0] pcq_rd;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   pcq       [DEPTH];
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;

  assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req    = !rst && (state == FETCH) && (inflight < DEPTH_L);
  assign imem_addr   = pc;
  assign grant       = imem_req && imem_gnt;
  assign drop        = imem_rvalid && (discard_cnt != '0);
  assign push        = imem_rvalid && !drop && !redirect;
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign discard_nxt = discard_cnt - CW'(drop);

  always_comb begin
    out_nxt = outstanding;
    if (grant)       out_nxt = out_nxt + CW'(1);
    if (imem_rvalid) out_nxt = out_nxt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      outstanding <= out_nxt;
      // The PC queue is never flushed: discarded responses still pop their entry.
      if (grant) begin
        pcq[pcq_wr] <= pc;
        pcq_wr      <= pcq_wr + PW'(1);
      end
      if (imem_rvalid) pcq_rd <= pcq_rd + PW'(1);

      if (redirect) begin
        fifo_count  <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        pc          <= redirect_pc & ~32'h3;
        discard_cnt <= out_nxt;
        state       <= (out_nxt != '0) ? DRAIN : FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (state == HALT || redirect_pc[1:0] != 2'b00) begin
          state        <= HALT;
          misalign_exc <= 1'b1;
        end
`endif
      end else begin
        if (grant) pc <= pc + 32'd4;
        discard_cnt <= discard_nxt;
        if (push) begin
          fifo_data[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]   <= pcq[pcq_rd];
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (state == DRAIN && discard_nxt == '0) state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency memory model.
// Build with FETCH_MISALIGN_CHECK_EN to exercise the HALT/misalign_exc path instead of alignment.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int tick   = 0;
  logic gnt_en = 1'b1;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_exc(misalign_exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0013_5A5A;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory acts 1 time unit after each negedge, after the main process has driven its inputs.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      tick++;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (rst) begin
        q_addr.delete();
        q_due.delete();
        imem_gnt = 1'b0;
      end else begin
        if (q_due.size() > 0 && q_due[0] <= tick) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        imem_gnt = gnt_en;
        if (imem_req && imem_gnt) begin
          q_addr.push_back(imem_addr);
          q_due.push_back(tick + lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    gnt_en      = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset values, then straight-line fetch with 1-cycle memory
    lat = 1;
    do_reset();
    check_val("rst_req",   {31'd0, imem_req},    32'd0);
    check_val("rst_addr",  imem_addr,            32'h0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_instr", instr,                32'h0);
    check_val("rst_pc",    instr_pc,             32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("rst_misalign", {31'd0, misalign_exc}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check_val("first_req",  {31'd0, imem_req}, 32'd1);
    check_val("first_addr", imem_addr,         32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_val("seq_addr", imem_addr,         32'(4 * i));
      check_val("seq_req",  {31'd0, imem_req}, 32'd1);
      if (i == 1) begin
        check_val("seq_valid0", {31'd0, instr_valid}, 32'd0);
      end else begin
        check_val("seq_valid", {31'd0, instr_valid}, 32'd1);
        check_val("seq_pc",    instr_pc,             32'(4 * (i - 2)));
        check_val("seq_instr", instr,                mem_word(32'(4 * (i - 2))));
      end
    end

    // Decode stalls for 10 cycles: FIFO fills to 4, requests stop, nothing lost
    do_reset();
    instr_ready = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 4) check_val("full_req", {31'd0, imem_req}, 32'd0);
    end
    check_val("full_valid", {31'd0, instr_valid}, 32'd1);
    check_val("full_head",  instr_pc,             32'h0);
    check_val("full_addr",  imem_addr,            32'h10);
    instr_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check_val("resume_req",  {31'd0, imem_req}, 32'd1);
        check_val("resume_addr", imem_addr,         32'h10);
      end
      check_val("resume_valid", {31'd0, instr_valid}, 32'd1);
      check_val("resume_pc",    instr_pc,             32'(4 * j));
    end

    // Redirect with 2 outstanding, latency 3
    lat = 3;
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100; gnt_en = 1'b0;
    @(negedge clk);
    redirect = 1'b0; gnt_en = 1'b1;
    check_val("drain_req0",  {31'd0, imem_req},    32'd0);
    check_val("drain_valid", {31'd0, instr_valid}, 32'd0);
    check_val("drain_addr",  imem_addr,            32'h100);
    @(negedge clk);
    check_val("drain_req1",  {31'd0, imem_req},    32'd0);
    @(negedge clk);
    check_val("redir_req",   {31'd0, imem_req},    32'd1);
    check_val("redir_addr",  imem_addr,            32'h100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("redir_wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    check_val("redir_valid", {31'd0, instr_valid}, 32'd1);
    check_val("redir_pc",    instr_pc,             32'h100);
    check_val("redir_instr", instr,                mem_word(32'h100));
    @(negedge clk);
    check_val("redir_pc2",   instr_pc,             32'h104);

    // Redirect in the same cycle as a response, a grant and a pop
    lat = 1;
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("combo_pre_pc", instr_pc, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    check_val("combo_valid", {31'd0, instr_valid}, 32'd0);
    check_val("combo_req",   {31'd0, imem_req},    32'd0);
    @(negedge clk);
    check_val("combo_req1",  {31'd0, imem_req},    32'd1);
    check_val("combo_addr",  imem_addr,            32'h200);
    check_val("combo_valid1",{31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check_val("combo_valid2",{31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check_val("combo_pc",    instr_pc,             32'h200);
    check_val("combo_instr", instr,                mem_word(32'h200));

    // PC wrap from 0xFFFF_FFFC to 0
    do_reset();
    gnt_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_val("hold_req",  {31'd0, imem_req}, 32'd1);
    check_val("hold_addr", imem_addr,         32'h0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    check_val("wrap_req",   {31'd0, imem_req}, 32'd1);
    check_val("wrap_addr0", imem_addr,         32'hFFFF_FFF8);
    gnt_en = 1'b1;
    @(negedge clk);
    check_val("wrap_addr1", imem_addr,         32'hFFFF_FFFC);
    @(negedge clk);
    check_val("wrap_addr2", imem_addr,         32'h0000_0000);
    check_val("wrap_pc0",   instr_pc,          32'hFFFF_FFF8);
    @(negedge clk);
    check_val("wrap_pc1",   instr_pc,          32'hFFFF_FFFC);
    @(negedge clk);
    check_val("wrap_pc2",   instr_pc,          32'h0000_0000);

    // Misaligned redirect to 0x102
    do_reset();
    gnt_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    gnt_en = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("mis_exc",  {31'd0, misalign_exc}, 32'd1);
    check_val("mis_req",  {31'd0, imem_req},     32'd0);
    repeat (3) @(negedge clk);
    check_val("mis_exc_sticky", {31'd0, misalign_exc}, 32'd1);
    check_val("mis_req_held",   {31'd0, imem_req},     32'd0);
    check_val("mis_valid",      {31'd0, instr_valid},  32'd0);
`else
    check_val("align_req",  {31'd0, imem_req}, 32'd1);
    check_val("align_addr", imem_addr,         32'h100);
    @(negedge clk);
    @(negedge clk);
    check_val("align_pc",   instr_pc,          32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
